// File: rtl/aes_pkg.sv
// Shared AES constants, GF(2^8) helpers and the core state encoding.
// Used by aes_round_comb and aes_encrypt_core.
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    KEYX,
    ROUND,
    HOLD
  } aes_state_e;

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    return SBOX_TBL[{b, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] n);
    logic [7:0] v;
    v = 8'h00;
    case (n)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic int nk(input int kb);
    return kb / 32;
  endfunction

  function automatic int nr(input int kb);
    return nk(kb) + 6;
  endfunction

endpackage

// File: rtl/aes_round_comb.sv
// One combinational AES round: SubBytes, ShiftRows,
// MixColumns (bypassed on the last round) and AddRoundKey.
module aes_round_comb
  import aes_pkg::*;
(
  input  logic [0:127] state,
  input  logic [0:127] rkey,
  input  logic         last,
  output logic [0:127] next
);

  logic [7:0] w_sb [16];
  logic [7:0] w_sr [16];
  logic [7:0] w_mc [16];
  logic [7:0] w_a0, w_a1, w_a2, w_a3;

  always_comb begin
    w_a0 = 8'h00;
    w_a1 = 8'h00;
    w_a2 = 8'h00;
    w_a3 = 8'h00;
    for (int i = 0; i < 16; i++)
      w_sb[i] = sbox(state[8*i +: 8]);
    // byte 4c+r is row r, column c
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        w_sr[4*c+r] = w_sb[4*((c+r)%4)+r];
    for (int c = 0; c < 4; c++) begin
      w_a0 = w_sr[4*c];
      w_a1 = w_sr[4*c+1];
      w_a2 = w_sr[4*c+2];
      w_a3 = w_sr[4*c+3];
      w_mc[4*c]   = xtime(w_a0) ^ xtime(w_a1) ^ w_a1 ^ w_a2 ^ w_a3;
      w_mc[4*c+1] = w_a0 ^ xtime(w_a1) ^ xtime(w_a2) ^ w_a2 ^ w_a3;
      w_mc[4*c+2] = w_a0 ^ w_a1 ^ xtime(w_a2) ^ xtime(w_a3) ^ w_a3;
      w_mc[4*c+3] = xtime(w_a0) ^ w_a0 ^ w_a1 ^ w_a2 ^ xtime(w_a3);
    end
    for (int i = 0; i < 16; i++)
      next[8*i +: 8] = (last ? w_sr[i] : w_mc[i]) ^ rkey[8*i +: 8];
  end

endmodule

// File: rtl/aes_encrypt_core.sv
// Iterative AES encryptor: in-core key expansion, one round per cycle.
// Optional abort input when AES_ABORT_EN is defined.
module aes_encrypt_core
  import aes_pkg::*;
#(
  parameter int KEY_BITS = 128
) (
  input  logic                clock,
  input  logic                reset_n,
`ifdef AES_ABORT_EN
  input  logic                abort,
`endif
  input  logic                start,
  input  logic [0:127]        plain_text,
  input  logic [0:KEY_BITS-1] key,
  input  logic                out_ready,
  output logic                busy,
  output logic [0:127]        enc_data,
  output logic                valid_flag
);

  localparam int NK = nk(KEY_BITS);
  localparam int NR = nr(KEY_BITS);
  localparam int NW = 4 * (NR + 1);
  localparam logic [5:0] NK6   = 6'(NK);
  localparam logic [5:0] LAST6 = 6'(NW - 1);
  localparam logic [3:0] NR4   = 4'(NR);
  localparam logic [2:0] KMAX  = 3'(NK - 1);

  if (KEY_BITS != 128 && KEY_BITS != 192 &&
      KEY_BITS != 256) begin : g_bad_keybits
    $error("aes_encrypt_core: KEY_BITS must be 128, 192 or 256");
  end

  aes_state_e   r_fsm, w_nxt;
  logic [31:0]  r_w [NW];
  logic [5:0]   r_idx;
  logic [2:0]   r_kmod;
  logic [3:0]   r_rcn;
  logic [3:0]   r_round;
  logic [0:127] r_st;
  logic [0:127] r_enc;
  logic         r_valid;

  logic         w_abort;
  logic [31:0]  w_prev, w_back, w_rot, w_sin, w_sub, w_f;
  logic [5:0]   w_rk;
  logic [0:127] w_rkey, w_rnd;
  logic         w_last;

`ifdef AES_ABORT_EN
  assign w_abort = abort && (r_fsm != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_prev = r_w[r_idx - 6'd1];
  assign w_back = r_w[r_idx - NK6];
  assign w_rot  = {w_prev[23:0], w_prev[31:24]};
  assign w_sin  = (r_kmod == 3'd0) ? w_rot : w_prev;
  assign w_sub  = {sbox(w_sin[31:24]), sbox(w_sin[23:16]),
                   sbox(w_sin[15:8]),  sbox(w_sin[7:0])};

  always_comb begin
    w_f = w_prev;
    if (r_kmod == 3'd0)
      w_f = w_sub ^ {rcon(r_rcn), 24'h0};
    else if (NK == 8 && r_kmod == 3'd4)
      w_f = w_sub;
  end

  assign w_rk   = {r_round, 2'b00};
  assign w_rkey = {r_w[w_rk], r_w[w_rk + 6'd1],
                   r_w[w_rk + 6'd2], r_w[w_rk + 6'd3]};
  assign w_last = (r_round == NR4);

  aes_round_comb u_round (
    .state (r_st),
    .rkey  (w_rkey),
    .last  (w_last),
    .next  (w_rnd)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) r_fsm <= IDLE;
    else          r_fsm <= w_nxt;
  end

  always_comb begin
    w_nxt = r_fsm;
    case (r_fsm)
      IDLE:  if (start) w_nxt = KEYX;
      KEYX:  if (r_idx == LAST6) w_nxt = ROUND;
      ROUND: if (w_last) w_nxt = HOLD;
      HOLD:  if (out_ready) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
    if (w_abort) w_nxt = IDLE;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int j = 0; j < NW; j++) r_w[j] <= '0;
      r_idx   <= '0;
      r_kmod  <= '0;
      r_rcn   <= '0;
      r_round <= '0;
      r_st    <= '0;
      r_enc   <= '0;
      r_valid <= 1'b0;
    end else if (w_abort) begin
      r_valid <= 1'b0;
    end else begin
      case (r_fsm)
        IDLE: if (start) begin
          for (int j = 0; j < NK; j++)
            r_w[j] <= key[32*j +: 32];
          r_st   <= plain_text ^ key[0:127];
          r_idx  <= NK6;
          r_kmod <= 3'd0;
          r_rcn  <= 4'd1;
        end
        KEYX: begin
          r_w[r_idx] <= w_back ^ w_f;
          r_idx      <= r_idx + 6'd1;
          r_kmod     <= (r_kmod == KMAX) ? 3'd0 : r_kmod + 3'd1;
          if (r_kmod == 3'd0) r_rcn <= r_rcn + 4'd1;
          if (r_idx == LAST6) r_round <= 4'd1;
        end
        ROUND: begin
          r_st    <= w_rnd;
          r_round <= r_round + 4'd1;
          if (w_last) begin
            r_enc   <= w_rnd;
            r_valid <= 1'b1;
          end
        end
        HOLD: if (out_ready) r_valid <= 1'b0;
        default: ;
      endcase
    end
  end

  assign busy       = (r_fsm != IDLE);
  assign enc_data   = r_enc;
  assign valid_flag = r_valid;

endmodule

// File: tb/tb_aes_encrypt_core.sv
// Scoreboard bench for aes_encrypt_core at 128/192/256-bit keys
// using the FIPS-197 appendix C vectors.
module tb_aes_encrypt_core;

  localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [255:0] K1  = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] K2  = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] K3  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

  typedef struct {
    int           k;
    logic [127:0] d;
    int           lat;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         abort_i = 1'b0;
  logic [127:0] pt = '0;
  logic [255:0] kk = '0;
  logic         start [3];
  logic         ordy [3];
  logic         busy [3];
  logic         valid [3];
  logic [127:0] dout [3];
  logic         pv [3];
  int           t0 [3];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  exp_t         q [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_encrypt_core #(.KEY_BITS(128)) u_d128 (
    .clock(clk), .reset_n(rst_n),
`ifdef AES_ABORT_EN
    .abort(abort_i),
`endif
    .start(start[0]), .plain_text(pt), .key(kk[255:128]),
    .out_ready(ordy[0]), .busy(busy[0]),
    .enc_data(dout[0]), .valid_flag(valid[0])
  );

  aes_encrypt_core #(.KEY_BITS(192)) u_d192 (
    .clock(clk), .reset_n(rst_n),
`ifdef AES_ABORT_EN
    .abort(abort_i),
`endif
    .start(start[1]), .plain_text(pt), .key(kk[255:64]),
    .out_ready(ordy[1]), .busy(busy[1]),
    .enc_data(dout[1]), .valid_flag(valid[1])
  );

  aes_encrypt_core #(.KEY_BITS(256)) u_d256 (
    .clock(clk), .reset_n(rst_n),
`ifdef AES_ABORT_EN
    .abort(abort_i),
`endif
    .start(start[2]), .plain_text(pt), .key(kk),
    .out_ready(ordy[2]), .busy(busy[2]),
    .enc_data(dout[2]), .valid_flag(valid[2])
  );

  task automatic chk(input string nm, input bit ok,
                     input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  task automatic do_start(input int k, input logic [127:0] p,
                          input logic [255:0] key, input logic [127:0] e,
                          input int lat, input bit push);
    exp_t x;
    @(negedge clk);
    pt = p;
    kk = key;
    if (push) begin
      x.k = k; x.d = e; x.lat = lat;
      q.push_back(x);
    end
    start[k] = 1'b1;
    @(posedge clk);
    #1;
    t0[k] = cyc;
    start[k] = 1'b0;
    chk("busy_after_accept", busy[k] == 1'b1, 128'(busy[k]), 128'd1);
  endtask

  task automatic wait_valid(input int k);
    int n;
    n = 0;
    while (!valid[k] && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("valid_timeout", valid[k] == 1'b1, 128'(n), 128'd200);
  endtask

  task automatic run_job(input int k, input logic [255:0] key,
                         input logic [127:0] e, input int lat);
    do_start(k, PT, key, e, lat, 1'b1);
    wait_valid(k);
    @(negedge clk);
    chk("idle_after_handshake", !busy[k] && !valid[k],
        {126'd0, busy[k], valid[k]}, 128'd0);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      start[k] = 1'b0;
      ordy[k]  = 1'b1;
      pv[k]    = 1'b0;
      t0[k]    = 0;
    end

    fork
      forever begin
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          if (valid[k] && !pv[k]) begin
            exp_t e;
            if (q.size() == 0) begin
              chk("unexpected_valid", 1'b0, dout[k], 128'd0);
            end else begin
              e = q.pop_front();
              chk("sb_dut", e.k == k, 128'(k), 128'(e.k));
              chk("sb_data", dout[k] == e.d, dout[k], e.d);
              chk("sb_latency", (cyc - t0[k]) == e.lat,
                  128'(cyc - t0[k]), 128'(e.lat));
            end
          end
          pv[k] = valid[k];
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++)
      chk("reset_state", !busy[k] && !valid[k] && dout[k] == '0,
          dout[k] | {126'd0, busy[k], valid[k]}, 128'd0);
    rst_n = 1'b1;

    run_job(0, K1, C1, 50);
    run_job(1, K2, C2, 58);
    run_job(2, K3, C3, 66);

    ordy[0] = 1'b0;
    do_start(0, PT, K1, C1, 50, 1'b1);
    wait_valid(0);
    for (int i = 0; i < 20; i++) begin
      if (i % 4 == 1) begin
        pt = ~PT;
        start[0] = 1'b1;
      end else begin
        start[0] = 1'b0;
      end
      @(negedge clk);
      chk("hold_stable", valid[0] && busy[0] && dout[0] == C1,
          dout[0], C1);
    end
    start[0] = 1'b0;
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("release_idle", !busy[0] && !valid[0],
        {126'd0, busy[0], valid[0]}, 128'd0);
    run_job(0, K1, C1, 50);

    do_start(0, PT, K1, C1, 50, 1'b0);
    repeat (17) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_reset", !busy[0] && !valid[0] && dout[0] == '0,
        dout[0] | {126'd0, busy[0], valid[0]}, 128'd0);
    rst_n = 1'b1;
    run_job(0, K1, C1, 50);

`ifdef AES_ABORT_EN
    do_start(0, ~PT, 256'd0, 128'd0, 0, 1'b0);
    repeat (45) @(negedge clk);
    abort_i = 1'b1;
    @(negedge clk);
    abort_i = 1'b0;
    chk("abort_idle", !busy[0] && !valid[0] && dout[0] == C1,
        dout[0] | {126'd0, busy[0], valid[0]}, C1);
    run_job(0, K1, C1, 50);
`endif

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", q.size() == 0, 128'(q.size()), 128'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
